// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures the high time of a hobby-servo PWM input and
// recovers the 8-bit angle code (1 ms -> 0, 2 ms -> 255, floor rounding).
// Also flags out-of-range pulses and loss of signal.
// Optional glitch filter: define SERVO_DEC_FILTER_EN to enable it.
module servo_pwm_decoder #(
  parameter int unsigned freq       = 50_000_000,
  parameter int unsigned TIMEOUT_MS = 25,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       angle_valid,
  output logic       pulse_err,
  output logic       signal_lost
);

  localparam logic [31:0] C1       = 32'(freq / 1000);
  localparam logic [31:0] CMIN     = C1 >> 1;
  localparam logic [31:0] CMAX     = (C1 * 32'd5) >> 1;
  localparam logic [31:0] TO_LIM   = 32'(TIMEOUT_MS) * C1;
  localparam logic [31:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEASURE,
    CHECK,
    DIVIDE
  } state_e;

  logic        sync1_q, sync2_q, prev_q;
  logic        level, rise, fall;
  logic [31:0] widthCnt_q, timeoutCnt_q;
  logic [31:0] excess, shiftedDiv;

  state_e      state_q, state_d;
  logic [31:0] width_q, width_d;
  logic [31:0] rem_q, rem_d;
  logic [7:0]  quo_q, quo_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  angle_q, angle_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        lost_q, lost_d;

  // Two-flop synchronizer; resets high so a pulse already present at reset
  // release never looks like a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef SERVO_DEC_FILTER_EN
  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  logic           filt_q;
  logic [FCW-1:0] filtCnt_q;

  // Glitch filter: follow the synced level only after it has disagreed with
  // the filtered level for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q    <= 1'b1;
      filtCnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      filtCnt_q <= '0;
    end else if (filtCnt_q == FCW'(FILTER_LEN - 1)) begin
      filt_q    <= sync2_q;
      filtCnt_q <= '0;
    end else begin
      filtCnt_q <= filtCnt_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // Delayed copy of the clean level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

  // High-time counter: restarts at 1 on a rise, counts high cycles, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               widthCnt_q <= '0;
    else if (rise)                            widthCnt_q <= 32'd1;
    else if (level && widthCnt_q != ALL_ONES) widthCnt_q <= widthCnt_q + 32'd1;
  end

  // Cycles since the last rising edge, saturating; drives signal-lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         timeoutCnt_q <= '0;
    else if (rise)                      timeoutCnt_q <= '0;
    else if (timeoutCnt_q != ALL_ONES)  timeoutCnt_q <= timeoutCnt_q + 32'd1;
  end

  // Part of the width above 1 ms, clamped to 1 ms; the divisor for the
  // current quotient bit is C1 shifted to that bit position.
  assign excess     = (width_q <= C1) ? 32'd0
                    : ((width_q - C1 > C1) ? C1 : width_q - C1);
  assign shiftedDiv = C1 << bit_q;

  // Decoder state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOW;
      width_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bit_q   <= '0;
      angle_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bit_q   <= bit_d;
      angle_q <= angle_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  // Measure, range-check, then divide (excess*255)/C1 one bit per cycle.
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bit_d   = bit_q;
    angle_d = angle_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    lost_d  = lost_q;

    if (timeoutCnt_q == TO_LIM) lost_d = 1'b1;

    case (state_q)
      WAIT_LOW: begin
        if (!level) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (fall) begin
          width_d = widthCnt_q;
          state_d = CHECK;
        end else if (level && widthCnt_q >= CMAX + 32'd1) begin
          err_d   = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      CHECK: begin
        if (width_q < CMIN) begin
          err_d   = 1'b1;
          state_d = WAIT_LOW;
        end else begin
          rem_d   = excess * 32'd255;
          quo_d   = '0;
          bit_d   = 3'd7;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (rem_q >= shiftedDiv) begin
          rem_d = rem_q - shiftedDiv;
          quo_d = quo_q | (8'd1 << bit_q);
        end
        if (bit_q == 3'd0) begin
          angle_d = quo_d;
          valid_d = 1'b1;
          lost_d  = 1'b0;
          state_d = WAIT_LOW;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  assign angle       = angle_q;
  assign angle_valid = valid_q;
  assign pulse_err   = err_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder: drives directed and random servo pulses and checks
// the decoded angle, strobes and status flags against a behavioural model.
`timescale 1ns/1ps
module tb_servo_pwm_decoder;

  localparam int unsigned FREQ = 1_000_000;
  localparam int C1     = 1000;
  localparam int CMIN   = C1 / 2;
  localparam int CMAX   = 5 * C1 / 2;
  localparam int TO_LIM = 25 * C1;
`ifdef SERVO_DEC_FILTER_EN
  localparam int LATENCY = 12 + 4;
`else
  localparam int LATENCY = 12;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] angle;
  logic       angle_valid;
  logic       pulse_err;
  logic       signal_lost;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int riseCyc = 0;
  int validCnt = 0;
  int errCnt = 0;
  int bothCnt = 0;
  int validCyc = 0;
  int lastAngle = 0;
  int expHeld = 0;
  logic lostAtValid = 1'b1;
  logic lostBeforeValid = 1'b0;
  logic prevLost = 1'b1;

  servo_pwm_decoder #(
    .freq(FREQ),
    .TIMEOUT_MS(25),
    .FILTER_LEN(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_in(pwm_in),
    .angle(angle),
    .angle_valid(angle_valid),
    .pulse_err(pulse_err),
    .signal_lost(signal_lost)
  );

  // Free-running clock and cycle counter used for latency and timeout checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (angle_valid) begin
      validCnt++;
      lastAngle = angle;
      validCyc = cyc;
      lostAtValid = signal_lost;
      lostBeforeValid = prevLost;
    end
    if (pulse_err) errCnt++;
    if (angle_valid && pulse_err) bothCnt++;
    prevLost = signal_lost;
  end

  // Reference model: -1 means the pulse is rejected, else the floor angle.
  function automatic int modelAngle(input int n);
    int ex;
    if (n < CMIN || n >= CMAX + 2) return -1;
    ex = (n <= C1) ? 0 : n - C1;
    if (ex > C1) ex = C1;
    return (ex * 255) / C1;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One pulse of highCycles clocks, optional 2-cycle low glitch, then a gap;
  // checks strobes, angle, latency and signal_lost against the model.
  task automatic applyStimulus(input int highCycles, input int lowCycles,
                               input int glitchAt, input string tag);
    int v0, e0, fallCyc, expA;
    v0 = validCnt;
    e0 = errCnt;
    @(posedge clk); #1 pwm_in = 1'b1; riseCyc = cyc;
    for (int i = 1; i <= highCycles; i++) begin
      @(posedge clk);
      if (glitchAt != 0 && i == glitchAt) #1 pwm_in = 1'b0;
      else if (glitchAt != 0 && i == glitchAt + 2) #1 pwm_in = 1'b1;
    end
    #1 pwm_in = 1'b0; fallCyc = cyc;
    repeat (lowCycles) @(posedge clk);
    #1;
    expA = modelAngle(highCycles);
    if (expA < 0) begin
      checkOutput($sformatf("%s.errStrobe", tag), errCnt - e0, 1);
      checkOutput($sformatf("%s.noValid", tag), validCnt - v0, 0);
      checkOutput($sformatf("%s.angleHold", tag), angle, expHeld);
    end else begin
      checkOutput($sformatf("%s.validCount", tag), validCnt - v0, 1);
      checkOutput($sformatf("%s.noErr", tag), errCnt - e0, 0);
      checkOutput($sformatf("%s.angle", tag), lastAngle, expA);
      checkOutput($sformatf("%s.latency", tag), validCyc - fallCyc, LATENCY);
      checkOutput($sformatf("%s.lostAtValid", tag), lostAtValid, 0);
      expHeld = expA;
    end
  endtask

  initial begin
    int a, w, diff;
    int angles[4] = '{0, 100, 200, 255};

    // Reset with the input already high: reset values, then a partial pulse.
    pwm_in = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset.angle", angle, 0);
    checkOutput("reset.valid", angle_valid, 0);
    checkOutput("reset.err", pulse_err, 0);
    checkOutput("reset.lost", signal_lost, 1);
    rst_n = 1'b1;
    repeat (600) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("partial.noValid", validCnt, 0);
    checkOutput("partial.noErr", errCnt, 0);

    applyStimulus(1500, 40, 0, "mid127");
    applyStimulus(1000, 40, 0, "w1000");
    applyStimulus(2000, 40, 0, "w2000");
    applyStimulus(800,  40, 0, "w800");
    applyStimulus(2400, 40, 0, "w2400");
    applyStimulus(400,  40, 0, "short400");
    applyStimulus(3000, 40, 0, "long3000");
    applyStimulus(499,  40, 0, "w499");
    applyStimulus(500,  40, 0, "w500");

    // Generator-style widths for known angles decode within +-2.
    for (int i = 0; i < 4; i++) begin
      a = angles[i];
      w = C1 + (a * C1) / 255;
      applyStimulus(w, 40, 0, $sformatf("loop%0d", a));
      diff = (lastAngle > a) ? lastAngle - a : a - lastAngle;
      checkOutput($sformatf("loop%0d.within2", a), (diff <= 2) ? 1 : 0, 1);
    end

    // Randomized widths, mostly in range with occasional over-long pulses.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 7) == 0) w = $urandom_range(2600, 2900);
      else                           w = $urandom_range(300, 2450);
      applyStimulus(w, $urandom_range(30, 80), 0, $sformatf("rnd%0d_w%0d", i, w));
    end

    // Loss of signal: no rise for the timeout period, then recovery.
    applyStimulus(1500, 40, 0, "preTimeout");
    while (cyc < riseCyc + TO_LIM - 10) @(posedge clk);
    #1;
    checkOutput("timeout.notYet", signal_lost, 0);
    while (cyc < riseCyc + TO_LIM + 20) @(posedge clk);
    #1;
    checkOutput("timeout.lost", signal_lost, 1);
    checkOutput("timeout.angleHold", angle, expHeld);
    applyStimulus(1800, 40, 0, "recover");
    checkOutput("recover.lostBefore", lostBeforeValid, 1);
    checkOutput("recover.lostAfter", signal_lost, 0);

    // Reset in the middle of a divide discards the result.
    begin
      int v0;
      v0 = validCnt;
      @(posedge clk); #1 pwm_in = 1'b1;
      repeat (2000) @(posedge clk);
      #1 pwm_in = 1'b0;
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("midReset.noValid", validCnt - v0, 0);
      checkOutput("midReset.angle", angle, 0);
      checkOutput("midReset.lost", signal_lost, 1);
      expHeld = 0;
    end
    applyStimulus(1500, 40, 0, "afterReset");

`ifdef SERVO_DEC_FILTER_EN
    applyStimulus(1500, 40, 700, "glitch1500");
    applyStimulus(1000, 40, 300, "glitch1000");
    applyStimulus(2000, 40, 1200, "glitch2000");
`endif

    checkOutput("validErrExclusive", bothCnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/servo_pwm_decoder.md
Name: servo_pwm_decoder

Overview:
- Receive-side counterpart of the team's servo PWM generator: measures the high time of an incoming hobby-servo PWM signal and recovers the 8-bit angle code.
- Signal format: 20 ms frame, high time 1 ms (angle 0) to 2 ms (angle 255), linear in between.
- Used for loopback self-test of servo outputs and for reading RC receiver channels.
- Outputs a registered angle with a one-cycle valid strobe, plus pulse-error and signal-lost status flags.

Parameters:
- freq, 50_000_000, clk frequency in Hz; derived CYCLES_1_MS = freq/1_000.
- TIMEOUT_MS, 25, frame timeout in ms; no rising edge for TIMEOUT_MS*CYCLES_1_MS cycles asserts signal_lost.
- FILTER_LEN, 4, stable-cycle count used only when SERVO_DEC_FILTER_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- pwm_in  input  1  asynchronous servo PWM input
- angle  output  8  last decoded angle code
- angle_valid  output  1  one-cycle strobe when angle updates
- pulse_err  output  1  one-cycle strobe when a pulse is rejected as out of range
- signal_lost  output  1  level; high while no valid frame is present

Behaviour:
- Reset values: angle=0, angle_valid=0, pulse_err=0, signal_lost=1. Internal counters=0, FSM=WAIT_LOW.
- Input path: 2-flop synchronizer, then a 1-cycle-delayed copy for edge detection. Rise = sync high & prev low; fall = sync low & prev high.
- Derived constants: C1=CYCLES_1_MS, C2=2*C1, CMIN=C1/2, CMAX=5*C1/2.
- Width counter: 32 bit; loads 1 on rise; increments each cycle while the synced input is high; saturates at all-ones.
- FSM states and transitions:
  - WAIT_LOW: wait for synced input low, then go to WAIT_RISE. Guarantees a pulse already high at reset release is discarded.
  - WAIT_RISE: on rise, go to MEASURE.
  - MEASURE: on fall, width = counter value, go to CHECK. If counter reaches CMAX+1 while still high: pulse_err strobe, go to WAIT_LOW.
  - CHECK: one cycle. If width < CMIN: pulse_err strobe, go to WAIT_LOW. Otherwise excess = (width<=C1) ? 0 : min(width-C1, C1), numerator = excess*255 (32 bit), go to DIVIDE.
  - DIVIDE: 8-iteration restoring shift-subtract divide of numerator by C1, one quotient bit per cycle, MSB first. Quotient always fits 8 bits because excess <= C1. After the 8th iteration go to WAIT_LOW.
- Output update: angle <= quotient and angle_valid=1 for exactly one cycle, 10 clk after the fall-detect cycle (CHECK 1 cycle + 8 DIVIDE cycles + 1 output register). signal_lost clears on the same cycle.
- Rounding: floor. Widths C1..C2 map linearly to 0..255; width < C1 clamps to 0; width in C2..CMAX clamps to 255.
- Timeout counter: reset to 0 on every rise; otherwise increments (saturating). On reaching TIMEOUT_MS*C1, signal_lost=1; it stays high until the next angle_valid. angle holds its last value.
- Edges during CHECK/DIVIDE are ignored; the FSM resynchronises via WAIT_LOW. No error is flagged.
- pulse_err and angle_valid are never high in the same cycle. Rejected pulses leave angle unchanged.
- rst_n low mid-operation aborts immediately to reset values. The result in flight is discarded.

Optional Feature:
- Macro SERVO_DEC_FILTER_EN.
- Defined: a glitch filter sits between the synchronizer and edge detection. The filtered level changes only after the synced input holds the new value for FILTER_LEN consecutive cycles. Both edges gain FILTER_LEN cycles of delay, so measured width is unchanged. Glitches shorter than FILTER_LEN are invisible.
- Undefined: synchronizer output feeds edge detection directly; no filter logic is generated.

Test Plan:
- freq=1_000_000 (C1=1000); frames of 20000 cycles, high 1500 cycles -> angle=127 and angle_valid for 1 cycle, 10 clk after fall detect; signal_lost drops at that strobe.
- High 1000, then 2000, then 800, then 2400 cycles -> angle=0, 255, 0, 255; no pulse_err.
- High 400 cycles -> pulse_err strobe, angle holds previous value. High held 3000 cycles -> pulse_err when counter passes 2500; no angle_valid.
- pwm_in high across rst_n release, then a 1500-cycle pulse -> first partial pulse produces no strobe; second gives angle=127.
- Valid frames, then pwm_in held low 25000 cycles after the last rise -> signal_lost=1. Next valid pulse -> signal_lost=0 with angle_valid.
- Loopback from the servo PWM generator (freq=1_000_000) with angles 0, 100, 200, 255 -> decoded within ±2. With SERVO_DEC_FILTER_EN, inject 2-cycle glitches mid-pulse -> same angles, no pulse_err.
